// File: rtl/freq_note_quantizer.sv
// Iterative pitch-to-note quantizer: octave-normalizes freq_in, then searches quarter-tone edges downward.
// Latency S+1+(12-note) cycles for a hit, S+1 for out-of-range, 0 for zero input; start always accepted (restarts).
module freq_note_quantizer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] freq_in,
    output logic        done,
    output logic        valid,
    output logic [3:0]  note_name,
    output logic [2:0]  note_octave,
    output logic        greater
);

    // Quarter-tone boundary below note k in octave 6 (A6 = 1760 Hz, 20 fractional bits).
    function automatic logic [31:0] edge_val(input int k);
        real r;
        r = 1845493760.0 * (2.0 ** ((real'(k) - 9.0) / 12.0 - 1.0 / 24.0));
        return 32'($rtoi(r + 0.5));
    endfunction

    localparam logic [31:0] NOTE_TAB [16] = '{
        32'h41680943, 32'h454bb03a, 32'h496a8b8f, 32'h4dc82080,
        32'h526829e4, 32'h574e9b58, 32'h5c7fa49f, 32'h61ffb539,
        32'h67d3802a, 32'h6e000000, 32'h748a7b12, 32'h7b788802,
        32'h0, 32'h0, 32'h0, 32'h0
    };

    localparam logic [31:0] EDGE_TAB [16] = '{
        edge_val(0), edge_val(1), edge_val(2),  edge_val(3),
        edge_val(4), edge_val(5), edge_val(6),  edge_val(7),
        edge_val(8), edge_val(9), edge_val(10), edge_val(11),
        32'h0, 32'h0, 32'h0, 32'h0
    };

    localparam logic [31:0] EDGE_HI = EDGE_TAB[0] << 1;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        SEARCH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] f_q, f_d;
    logic [2:0]  oct_q, oct_d;
    logic [3:0]  k_q, k_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [3:0]  note_name_q, note_name_d;
    logic [2:0]  note_octave_q, note_octave_d;
    logic        greater_q, greater_d;

    always_comb begin
        state_d       = state_q;
        f_d           = f_q;
        oct_d         = oct_q;
        k_d           = k_q;
        done_d        = done_q;
        valid_d       = valid_q;
        note_name_d   = note_name_q;
        note_octave_d = note_octave_q;
        greater_d     = greater_q;

        if (start) begin
            // A new start overrides whatever conversion is in flight.
            if (freq_in == 32'd0) begin
                state_d = IDLE;
                done_d  = 1'b1;
                valid_d = 1'b0;
            end else begin
                f_d     = freq_in;
                oct_d   = 3'd6;
                done_d  = 1'b0;
                state_d = NORM;
            end
        end else begin
            case (state_q)
                IDLE: begin
                end
                NORM: begin
                    if (f_q < EDGE_TAB[0]) begin
                        if (oct_q == 3'd0) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            f_d   = {f_q[30:0], 1'b0};
                            oct_d = oct_q - 3'd1;
                        end
                    end else if (f_q >= EDGE_HI) begin
                        if (oct_q == 3'd7) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            f_d   = {1'b0, f_q[31:1]};
                            oct_d = oct_q + 3'd1;
                        end
                    end else begin
                        k_d     = 4'd11;
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    // k reaching 0 always hits since NORM left f >= EDGE_TAB[0].
                    if (f_q >= EDGE_TAB[k_q]) begin
                        note_name_d   = k_q;
                        note_octave_d = oct_q;
                        greater_d     = (f_q >= NOTE_TAB[k_q]);
                        valid_d       = 1'b1;
                        done_d        = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        k_d = k_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            f_q           <= 32'd0;
            oct_q         <= 3'd0;
            k_q           <= 4'd0;
            done_q        <= 1'b1;
            valid_q       <= 1'b0;
            note_name_q   <= 4'd0;
            note_octave_q <= 3'd0;
            greater_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            f_q           <= f_d;
            oct_q         <= oct_d;
            k_q           <= k_d;
            done_q        <= done_d;
            valid_q       <= valid_d;
            note_name_q   <= note_name_d;
            note_octave_q <= note_octave_d;
            greater_q     <= greater_d;
        end
    end

    assign done        = done_q;
    assign valid       = valid_q;
    assign note_name   = note_name_q;
    assign note_octave = note_octave_q;
    assign greater     = greater_q;

endmodule

// File: tb/tb_freq_note_quantizer.sv
// Bench for freq_note_quantizer: directed vector table, restart/reset sequences, and
// randomized frequencies checked against an arithmetic note model.
module tb_freq_note_quantizer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] freq_in;
    logic        done;
    logic        valid;
    logic [3:0]  note_name;
    logic [2:0]  note_octave;
    logic        greater;

    freq_note_quantizer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .freq_in     (freq_in),
        .done        (done),
        .valid       (valid),
        .note_name   (note_name),
        .note_octave (note_octave),
        .greater     (greater)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint edge_v [12];
    longint note_tab [12] = '{
        64'h41680943, 64'h454bb03a, 64'h496a8b8f, 64'h4dc82080,
        64'h526829e4, 64'h574e9b58, 64'h5c7fa49f, 64'h61ffb539,
        64'h67d3802a, 64'h6e000000, 64'h748a7b12, 64'h7b788802
    };

    // Model's view of the held outputs plus the latency of the last conversion.
    int m_name, m_oct, m_grt, m_vld, m_lat;

    typedef struct {
        logic [31:0] freq;
        int          name;
        int          oct;
        int          grt;
        int          vld;
        int          lat;
        string       tag;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, exp);
        end
    endtask

    task automatic run_conv(input logic [31:0] fr, output int lat);
        @(negedge clk);
        start   = 1'b1;
        freq_in = fr;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    // Octave from how far the input must be scaled into [edge0, 2*edge0); note = highest edge not above it.
    function automatic void model_conv(input logic [31:0] fr);
        longint f, fn, ehi;
        int s, oct, k;
        f   = {32'd0, fr};
        ehi = 2 * edge_v[0];
        if (f == 0) begin
            m_vld = 0;
            m_lat = 0;
            return;
        end
        if (f >= ehi) begin
            fn  = f / 2;
            s   = 1;
            oct = 7;
            if (fn >= ehi) begin
                m_vld = 0;
                m_lat = 2;
                return;
            end
        end else begin
            s = 0;
            while (s < 7 && (f << s) < edge_v[0]) s++;
            if (s == 7) begin
                m_vld = 0;
                m_lat = 7;
                return;
            end
            fn  = f << s;
            oct = 6 - s;
        end
        k = 0;
        for (int i = 1; i < 12; i++) if (fn >= edge_v[i]) k = i;
        m_name = k;
        m_oct  = oct;
        m_grt  = (fn >= note_tab[k]) ? 1 : 0;
        m_vld  = 1;
        m_lat  = s + 1 + 12 - k;
    endfunction

    initial begin
        int lat;
        int mode, kk, sh;
        longint t;
        logic [31:0] fr;

        for (int k = 0; k < 12; k++)
            edge_v[k] = longint'($floor(1845493760.0 * (2.0 ** ((real'(k) - 9.0) / 12.0 - 1.0 / 24.0)) + 0.5));

        vecs[0] = '{32'h1B800000,  9, 4, 1, 1,  6, "a4_tune"};
        vecs[1] = '{32'h1B7FFFFF,  9, 4, 0, 1,  6, "a4_flat"};
        vecs[2] = '{32'h41680943,  0, 6, 1, 1, 13, "c6_exact"};
        vecs[3] = '{32'hFFFFFFFF,  0, 6, 1, 0,  2, "over"};
        vecs[4] = '{32'h00000001,  0, 6, 1, 0,  7, "under"};
        vecs[5] = '{32'h00000000,  0, 6, 1, 0,  0, "zero"};
        vecs[6] = '{32'h7B788802, 11, 6, 1, 1,  2, "b6_min"};
        vecs[7] = '{32'h0105A025,  0, 0, 0, 1, 19, "c0_max"};

        start   = 1'b0;
        freq_in = 32'd0;
        reset   = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_done",  done,        1);
        chk("rst_valid", valid,       0);
        chk("rst_name",  note_name,   0);
        chk("rst_oct",   note_octave, 0);
        chk("rst_grt",   greater,     0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].freq, lat);
            chk({vecs[i].tag, "_lat"},   lat,         vecs[i].lat);
            chk({vecs[i].tag, "_valid"}, valid,       vecs[i].vld);
            chk({vecs[i].tag, "_name"},  note_name,   vecs[i].name);
            chk({vecs[i].tag, "_oct"},   note_octave, vecs[i].oct);
            chk({vecs[i].tag, "_grt"},   greater,     vecs[i].grt);
        end

        // Restart: A4 launched, C6 start lands on E0+4; only the C6 result may appear.
        @(negedge clk);
        start   = 1'b1;
        freq_in = 32'h1B800000;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("restart_busy", done, 0);
            @(posedge clk);
            #1;
        end
        chk("restart_busy", done, 0);
        @(negedge clk);
        start   = 1'b1;
        freq_in = 32'h41680943;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("restart_lat",   lat,         13);
        chk("restart_valid", valid,       1);
        chk("restart_name",  note_name,   0);
        chk("restart_oct",   note_octave, 6);
        chk("restart_grt",   greater,     1);

        // Asynchronous reset in the middle of an A4 conversion.
        @(negedge clk);
        start   = 1'b1;
        freq_in = 32'h1B800000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_done",  done,        1);
        chk("mid_rst_valid", valid,       0);
        chk("mid_rst_name",  note_name,   0);
        chk("mid_rst_oct",   note_octave, 0);
        chk("mid_rst_grt",   greater,     0);
        @(negedge clk);
        reset = 1'b0;
        run_conv(32'h1B800000, lat);
        chk("post_rst_lat",   lat,         6);
        chk("post_rst_valid", valid,       1);
        chk("post_rst_name",  note_name,   9);
        chk("post_rst_oct",   note_octave, 4);
        chk("post_rst_grt",   greater,     1);

        m_name = 9;
        m_oct  = 4;
        m_grt  = 1;
        m_vld  = 1;

        for (int n = 0; n < 250; n++) begin
            mode = $urandom_range(0, 15);
            if (mode == 0) begin
                fr = 32'd0;
            end else if (mode < 6) begin
                fr = $urandom;
            end else if (mode < 11) begin
                fr = $urandom >> $urandom_range(1, 31);
            end else begin
                kk = $urandom_range(0, 11);
                sh = $urandom_range(0, 7);
                t  = (edge_v[kk] >> sh) + longint'($urandom_range(0, 4)) - 2;
                if (mode == 15) t = (note_tab[kk] >> sh) + longint'($urandom_range(0, 2)) - 1;
                fr = t[31:0];
            end
            run_conv(fr, lat);
            model_conv(fr);
            chk("rnd_lat",   lat,         m_lat);
            chk("rnd_valid", valid,       m_vld);
            chk("rnd_name",  note_name,   m_name);
            chk("rnd_oct",   note_octave, m_oct);
            chk("rnd_grt",   greater,     m_grt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_note_quantizer.md
# freq_note_quantizer

Converts a measured pitch frequency into the nearest equal-tempered note name, octave and above/below flag. It is the inverse of `scale_freq_select`: it sits between the pitch detector and `scale_freq_select`, and produces the `note_name`, `note_octave` and `greater` inputs that block consumes. It is a multi-cycle iterative search, started by a `start`/`done` handshake.

## Interface
- No parameters. Thresholds and note constants are fixed, as defined in Operation.
- `clk` — in — 1 — system clock; all state changes on its rising edge.
- `reset` — in — 1 — asynchronous, active-high reset.
- `start` — in — 1 — single-cycle pulse; samples `freq_in` and begins a conversion.
- `freq_in` — in — 32 — unsigned frequency in Hz, 20 fractional bits (same format as `freq_desired`).
- `done` — out — 1 — high when idle and when the outputs are valid.
- `valid` — out — 1 — the last conversion landed inside octaves 0..7.
- `note_name` — out — 4 — note index 0 = C … 11 = B.
- `note_octave` — out — 3 — octave number, 0..7.
- `greater` — out — 1 — measured frequency is ≥ the exact note frequency.

## Operation
- **Note constants** `note_tab[k]`, for k = 0..11, are the octave-6 values, identical to the `scale_freq_select` table:
  - 41680943, 454bb03a, 496a8b8f, 4dc82080, 526829e4, 574e9b58
  - 5c7fa49f, 61ffb539, 67d3802a, 6e000000, 748a7b12, 7b788802
- **Edge constants** `edge[k] = round(2^20 · 1760 · 2^((k−9)/12 − 1/24))`. This is the quarter-tone boundary below note k in octave 6. `EDGE_HI = 2·edge[0]`.
- **States:** IDLE, NORM, SEARCH.
- **IDLE**
  - `start=1`: latch `f ← freq_in`, `oct ← 6`, `done ← 0`, go to NORM.
  - If `freq_in == 0`: stay in IDLE, `done ← 1`, `valid ← 0`.
- **NORM** (one decision per cycle):
  - `f < edge[0]`, `oct == 0`: `valid ← 0`, `done ← 1`, go to IDLE.
  - `f < edge[0]`, otherwise: `f ← f << 1`, `oct ← oct − 1`.
  - `f ≥ EDGE_HI`, `oct == 7`: `valid ← 0`, `done ← 1`, go to IDLE.
  - `f ≥ EDGE_HI`, otherwise: `f ← f >> 1` (LSB discarded), `oct ← oct + 1`.
  - Otherwise: `k ← 11`, go to SEARCH.
- **SEARCH** (one compare per cycle):
  - `f ≥ edge[k]`: `note_name ← k`, `note_octave ← oct`, `greater ← (f ≥ note_tab[k])`, `valid ← 1`, `done ← 1`, go to IDLE.
  - Otherwise: `k ← k − 1`.
  - k = 0 always hits, because NORM guarantees `f ≥ edge[0]`.
- **Output holding:** `note_name`, `note_octave`, `greater` and `valid` are registered. They change only when a conversion finishes. On `valid=0` finishes they keep their previous values, except `valid`.
- **Comparisons:** all are 32-bit unsigned. `f << 1` never overflows, because it only happens when `f < edge[0] < 2^31`.
- **Restart:** `start` in NORM or SEARCH aborts the current conversion and restarts from IDLE behaviour with the new `freq_in`. `done` stays 0, except for the zero-input case.

## Timing
- **Reset values:** `done=1`, `valid=0`, `note_name=0`, `note_octave=0`, `greater=0`, state IDLE.
- **Reset mid-conversion:** the same values apply immediately (asynchronous), and the conversion is lost.
- Let E0 be the edge that samples `start`. `done` falls after E0.
- **Valid conversion latency:** `done` rises after edge E0 + S + 1 + (12 − note_name), where S is the number of NORM shifts.
  - Minimum is 2 cycles (S=0, B).
  - Maximum is 19 cycles (S=6, C).
- **Out-of-range latency:** `done` rises after E0 + S + 1.
- **Zero input:** `done` is high again after E0 itself, so the low pulse is 0 cycles.
- **Start while done=1:** accepted on any cycle. No back-pressure.
- **`done` in IDLE:** remains high with no further pulses. The consumer detects completion on the 0→1 edge of `done`.

## Test plan
- **A4, in tune.** `freq_in=0x1B800000` (440 Hz) → two shifts, then SEARCH hits at k=9.
  - Expect `note_name=9`, `note_octave=4`, `greater=1`, `valid=1`.
  - Expect `done` high after E0+6.
- **A4, slightly flat.** `freq_in=0x1B7FFFFF` → `note_name=9`, `note_octave=4`, `greater=0`, `valid=1`.
- **C6, exact.** `freq_in=0x41680943` → S=0, `note_name=0`, `note_octave=6`, `greater=1`.
  - Expect `done` after E0+13.
- **Range errors.**
  - `freq_in=0xFFFFFFFF` → one right shift, then `oct=7` with `f ≥ EDGE_HI`. Expect `valid=0`, `done` after E0+2.
  - `freq_in=0x00000001` → underflow at `oct=0`. Expect `valid=0`, `done` after E0+7.
  - `freq_in=0` → `valid=0`, `done` never drops.
- **Restart mid-search.** Start with 440 Hz, then assert `start` with `0x41680943` on cycle E0+4.
  - Expect only the C6 result (`note_name=0`, `note_octave=6`), `done` rising 13 cycles after the second start.
- **Reset mid-conversion.** Assert `reset` at E0+3 of an A4 conversion.
  - Expect all outputs at reset values asynchronously, and a clean new conversion on the next `start`.
